// File: rtl/path_lane_decoder_if.sv
// path_lane_decoder_if : handshake bundle between the lane decoder and its source/sink.
// rev 1.0
`default_nettype none

interface path_lane_decoder_if #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_LANES*LANE_W-1:0] in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANE_W-1:0]           out_data;
  logic [LW-1:0]               out_lane;
  logic                        out_last;
  logic                        chk_valid;
  logic [LANE_W-1:0]           chk_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_lane, out_last, chk_valid, chk_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_lane, out_last, chk_valid, chk_data
  );
endinterface

`default_nettype wire

// File: rtl/path_lane_decoder.sv
// path_lane_decoder : strips per-lane index offsets, serialises lanes at a ÷1/÷2/÷4 enable rate,
// closes each word with an XOR checksum. rev 1.0
`default_nettype none

module path_lane_decoder #(
  parameter int NUM_LANES = 4,
  parameter int LANE_W    = 8
) (
  input wire              clk_in,
  input wire              rst,
  input wire [1:0]        div_sel,
  path_lane_decoder_if.slave bus
);
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int IW = LW + 1;
  localparam logic [IW-1:0] C_NUM  = IW'(NUM_LANES);
  localparam logic [IW-1:0] C_LAST = IW'(NUM_LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                      r_state;
  logic [NUM_LANES*LANE_W-1:0] r_word;
  logic [1:0]                  r_div;
  logic [1:0]                  r_cnt;
  logic [IW-1:0]               r_idx;
  logic [LANE_W-1:0]           r_acc;
  logic [LANE_W-1:0]           r_out_data;
  logic [LW-1:0]               r_out_lane;
  logic                        r_out_valid;
  logic                        r_out_last;
  logic                        r_chk_valid;
  logic [LANE_W-1:0]           r_chk_data;

  logic [LANE_W-1:0] w_lane [NUM_LANES];
  logic              w_tick;
  logic              w_hs;
  logic [IW-1:0]     w_ld_idx;
  logic              w_load;
  logic [LANE_W-1:0] w_ld_data;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign w_lane[gi] = r_word[gi*LANE_W +: LANE_W];
    end
  endgenerate

  always_comb begin
    w_tick = 1'b0;
    case (r_div)
      2'b00:   w_tick = 1'b1;
      2'b01:   w_tick = r_cnt[0];
      default: w_tick = (r_cnt == 2'd3);
    endcase
  end

  // A handshake and a load can share a cycle; the loaded lane is then the one after idx.
  assign w_hs      = r_out_valid && bus.out_ready;
  assign w_ld_idx  = w_hs ? (r_idx + IW'(1)) : r_idx;
  assign w_load    = (r_state == S_SEND) && w_tick && (!r_out_valid || bus.out_ready)
                     && (w_ld_idx < C_NUM);
  assign w_ld_data = w_lane[w_ld_idx[LW-1:0]] - LANE_W'(w_ld_idx);

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_word      <= '0;
      r_div       <= 2'b00;
      r_cnt       <= 2'd0;
      r_idx       <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_lane  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_chk_valid <= 1'b0;
      r_chk_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_word  <= bus.in_data;
            r_div   <= div_sel;
            r_idx   <= '0;
            r_cnt   <= 2'd0;
            r_acc   <= '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          r_cnt <= r_cnt + 2'd1;
          if (w_hs) begin
            r_acc <= r_acc ^ r_out_data;
            r_idx <= r_idx + IW'(1);
          end
          if (w_load) begin
            r_out_data  <= w_ld_data;
            r_out_lane  <= w_ld_idx[LW-1:0];
            r_out_last  <= (w_ld_idx == C_LAST);
            r_out_valid <= 1'b1;
          end else if (w_hs) begin
            r_out_valid <= 1'b0;
          end
          if (w_hs && r_out_last) begin
            r_chk_valid <= 1'b1;
            r_chk_data  <= r_acc ^ r_out_data;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_chk_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE) && !rst;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_lane  = r_out_lane;
  assign bus.out_last  = r_out_last;
  assign bus.chk_valid = r_chk_valid;
  assign bus.chk_data  = r_chk_data;

endmodule

`default_nettype wire

// File: tb/tb_path_lane_decoder.sv
// tb_path_lane_decoder : scoreboard bench for path_lane_decoder with a lane-arithmetic reference model.
// rev 1.0
`default_nettype none

module tb_path_lane_decoder;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LW = 2;

  logic       clk_in = 1'b0;
  logic       rst    = 1'b1;
  logic [1:0] div_sel = 2'b00;
  int         mode = 0;
  bit         rbit = 1'b1;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;

  path_lane_decoder_if #(.NUM_LANES(N), .LANE_W(W)) bus ();

  path_lane_decoder #(.NUM_LANES(N), .LANE_W(W)) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .div_sel (div_sel),
    .bus     (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;
  always @(posedge clk_in) begin
    #1 rbit = ($urandom % 4) != 0;
  end
  assign bus.out_ready = (mode == 0) || (mode == 1 && rbit);

  typedef struct { logic [W-1:0] data; int lane; bit last; int cyc; } lane_t;
  typedef struct { logic [W-1:0] data; int cyc; } chk_t;
  lane_t lq[$];
  chk_t  cq[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations on every handshake and checksum strobe.
  lane_t         m_it;
  chk_t          m_ck;
  bit            holding = 0;
  bit            after_chk = 0;
  logic [W-1:0]  hold_d;
  logic [LW-1:0] hold_l;
  always @(negedge clk_in) begin
    if (rst) begin
      holding   = 0;
      after_chk = 0;
    end else begin
      if (after_chk) check("in_ready_after_chk", bus.in_ready, 1);
      after_chk = 0;
      if (holding) begin
        if (bus.out_valid) begin
          check("stall_data", bus.out_data, hold_d);
          check("stall_lane", bus.out_lane, hold_l);
        end else begin
          checks++; errors++;
          $display("FAIL stall_valid actual=0 expected=1");
        end
      end
      holding = 0;
      if (bus.out_valid) begin
        check("in_ready_busy", bus.in_ready, 0);
        if (bus.out_ready) begin
          if (lq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_lane actual=%0h expected=none", bus.out_data);
          end else begin
            m_it = lq.pop_front();
            check("lane_data", bus.out_data, m_it.data);
            check("lane_idx", bus.out_lane, m_it.lane);
            check("lane_last", bus.out_last, m_it.last);
            if (m_it.cyc >= 0) check("lane_cycle", cyc, m_it.cyc);
          end
        end else begin
          holding = 1;
          hold_d  = bus.out_data;
          hold_l  = bus.out_lane;
        end
      end
      if (bus.chk_valid) begin
        if (cq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_chk actual=%0h expected=none", bus.chk_data);
        end else begin
          m_ck = cq.pop_front();
          check("chk_data", bus.chk_data, m_ck.data);
          if (m_ck.cyc >= 0) check("chk_cycle", cyc, m_ck.cyc);
          after_chk = 1;
        end
      end
    end
  end

  // Offers one word, pushes the model's lanes/checksum once accepted.
  task automatic send(input logic [N*W-1:0] word, input logic [1:0] ds, input bit timed);
    int t, d, acc, raw, v;
    bit ok;
    @(posedge clk_in); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    div_sel      = ds;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (bus.in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=0 expected=1");
      bus.in_valid = 1'b0;
      return;
    end
    t   = cyc + 1;
    d   = (ds == 2'b00) ? 1 : (ds == 2'b01) ? 2 : 4;
    acc = 0;
    for (int k = 0; k < N; k++) begin
      raw = int'((word >> (k * W)) & ((1 << W) - 1));
      v   = (raw - k + (1 << W)) % (1 << W);
      acc = acc ^ v;
      lq.push_back('{data: W'(v), lane: k, last: (k == N - 1), cyc: timed ? t + d * (k + 1) : -1});
    end
    cq.push_back('{data: W'(acc), cyc: timed ? t + d * N + 1 : -1});
    @(posedge clk_in); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_in);
      if (lq.size() == 0 && cq.size() == 0 && bus.in_ready) return;
    end
    checks++; errors++;
    $display("FAIL drain_timeout actual=%0d expected=0", lq.size() + cq.size());
  endtask

  task automatic wait_lane(input int l);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (bus.out_valid && bus.out_lane == LW'(l)) return;
    end
    checks++; errors++;
    $display("FAIL lane_wait_timeout actual=none expected=%0d", l);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    @(negedge clk_in);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_lane", bus.out_lane, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_chk_valid", bus.chk_valid, 0);
    check("rst_chk_data", bus.chk_data, 0);
    check("rst_in_ready", bus.in_ready, 0);
    @(posedge clk_in); #1 rst = 1'b0;
    #1 check("release_in_ready", bus.in_ready, 1);

    send(32'h44332211, 2'b00, 1); wait_idle();
    send(32'h01000000, 2'b00, 1); wait_idle();
    send(32'h44332211, 2'b10, 1); wait_idle();
    send(32'h44332211, 2'b01, 1); wait_idle();

    // Backpressure on lane 1 at ÷2.
    send(32'h44332211, 2'b01, 0);
    wait_lane(0);
    @(posedge clk_in); #1 mode = 2;
    wait_lane(1);
    check("bp_lane1_data", bus.out_data, 8'h21);
    repeat (5) @(negedge clk_in);
    @(posedge clk_in); #1 mode = 0;
    wait_idle();

    // div_sel change mid-word must not alter the word in flight.
    send(32'hA5C3_0F7E, 2'b00, 1);
    div_sel = 2'b10;
    wait_idle();
    send(32'h1234_5678, 2'b10, 1); wait_idle();

    // Reset after lane 1 handshake.
    send(32'h8899_AABB, 2'b00, 0);
    wait_lane(1);
    @(posedge clk_in); #1 rst = 1'b1;
    lq.delete(); cq.delete();
    #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_chk_valid", bus.chk_valid, 0);
    check("abort_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk_in);
    #1 rst = 1'b0;
    #1;
    check("abort_release_in_ready", bus.in_ready, 1);
    check("abort_chk_data", bus.chk_data, 0);
    send(32'h44332211, 2'b00, 1); wait_idle();

    for (int i = 0; i < 6; i++) begin
      send({$urandom}, 2'($urandom_range(0, 3)), 1);
      wait_idle();
    end
    mode = 1;
    for (int i = 0; i < 20; i++) begin
      send({$urandom}, 2'($urandom_range(0, 3)), 0);
      wait_idle();
    end
    mode = 0;
    wait_idle();
    repeat (3) @(negedge clk_in);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/path_lane_decoder.md
# path_lane_decoder

Single-clock decoder for the per-path lane format produced by the clock-path array. It accepts a packed multi-lane word and removes each lane's index offset (lane i carries payload + i). It then emits the lanes one at a time on a byte stream at a programmable clock-enable rate (÷1/÷2/÷4) and closes each word with an XOR checksum. It replaces divided clocks with enables, so everything runs on `clk_in`.

## Interface
Parameters:
- `NUM_LANES`, 4, number of lanes per word (2..8)
- `LANE_W`, 8, lane width in bits

Ports (clock and reset first):
- `clk_in` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `div_sel` in 2: lane-emit rate, sampled at word acceptance.
  - 00 = every cycle (÷1).
  - 01 = ÷2.
  - 10 and 11 = ÷4.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: block can accept a word.
- `in_data` in NUM_LANES*LANE_W: lane i at `[i*LANE_W +: LANE_W]`.
- `out_valid` out 1: decoded lane valid.
- `out_ready` in 1: consumer accepts lane.
- `out_data` out LANE_W: decoded lane value.
- `out_lane` out $clog2(NUM_LANES): index of the lane on `out_data`.
- `out_last` out 1: the current lane is lane NUM_LANES-1.
- `chk_valid` out 1: single-cycle checksum strobe.
- `chk_data` out LANE_W: XOR of all decoded lanes of the finished word.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SEND: lanes in flight.
  - DONE: emit checksum.
- IDLE → SEND on `in_valid && in_ready`. On this transition the block:
  - captures `in_data` into the word register;
  - latches `div_sel` into `div_r`;
  - clears lane index `idx` = 0, enable counter `cnt` = 0 and checksum accumulator `acc` = 0.
- `cnt` is 2 bits. It increments every cycle in SEND and wraps 3 → 0.
- `tick` is combinational:
  - `div_r`=00 → 1.
  - `div_r`=01 → `cnt[0]`.
  - `div_r`≥10 → `cnt==3`.
- Load condition in SEND: `tick && (!out_valid || out_ready) && lanes_remaining`. On load:
  - `out_data` ← (word lane[`idx`] − `idx`), truncated to LANE_W, i.e. modulo 2^LANE_W.
  - `out_lane` ← `idx`.
  - `out_last` ← (`idx`==NUM_LANES-1).
  - `out_valid` ← 1.
- Output handshake completes on `out_valid && out_ready`. On completion:
  - `acc` ^= `out_data`;
  - `idx` increments;
  - `out_valid` clears unless a new load occurs in the same cycle.
- `out_data`, `out_lane` and `out_last` are held stable while `out_valid && !out_ready`. Backpressure stalls lane advance but not `cnt`.
- Handshake on the last lane → DONE.
- DONE (one cycle):
  - `chk_valid`=1;
  - `chk_data` = final `acc`, including the last lane;
  - then → IDLE.
- `chk_data` holds its value until the next DONE.
- There is no overlap between words: `in_ready`=0 in SEND and DONE.
- `div_sel` changes during SEND have no effect until the next acceptance.

## Timing
- Reset values (while `rst`=1 and immediately after):
  - state IDLE;
  - all of `out_valid`, `out_data`, `out_lane`, `out_last`, `chk_valid`, `chk_data`, `cnt`, `idx` and `acc` = 0;
  - `in_ready` = 0 while `rst`=1 and 1 from the first cycle after deassertion.
- Acceptance at edge T → first `out_valid` at T+1 (÷1), T+2 (÷2) or T+4 (÷4).
- With `out_ready` held high, lanes appear every 1/2/4 cycles.
  - At ÷2 and ÷4, `out_valid` drops between lanes.
  - At ÷1, `out_valid` stays high for NUM_LANES consecutive cycles.
- `chk_valid` is asserted the cycle after the last handshake. `in_ready`=1 the following cycle.
  - ÷1 word period with no stalls: NUM_LANES+2 cycles.
- If a stall ends on a cycle where `tick`=0, the next lane waits for the next `tick`.
- Reset asserted mid-word: immediate abort. All outputs go to reset values asynchronously and no partial checksum is emitted.

## Test plan
- ÷1, `out_ready`=1, `in_data`=0x44332211:
  - `out_data` 0x11, 0x21, 0x31, 0x41 on consecutive cycles;
  - `out_lane` 0..3, `out_last` only on lane 3;
  - `chk_data`=0x40.
- Wrap-around, ÷1, `in_data`=0x01000000:
  - `out_data` 0x00, 0xFF, 0xFE, 0xFE;
  - `chk_data`=0xFF.
- ÷4, `in_data`=0x44332211 accepted at T:
  - `out_valid` pulses at T+4, T+8, T+12, T+16;
  - `chk_valid` at T+17.
- Backpressure, ÷2: hold `out_ready`=0 for 5 cycles on lane 1.
  - `out_data`=0x21 stays stable throughout;
  - no lane skipped or duplicated;
  - `chk_data` still 0x40.
- `div_sel` toggled 00→10 during SEND of a ÷1 word: the word completes at the ÷1 rate, and the next accepted word runs at ÷4.
- `rst` pulsed after lane 1's handshake:
  - `out_valid`=0 and `chk_valid` never asserts;
  - `in_ready`=1 after release;
  - the next word decodes correctly from lane 0.
